// File: rtl/mpc_dot_accum_29s_21s.sv
// Dot-product accumulator behind the 3-cycle ce-gated 21s x 8s multiplier.
// Aligns operand tags with the product stream, accumulates, then rounds and saturates to 21 bits.
//
// state | meaning
// IDLE  | no dot product open, waiting for a first-tagged term
// ACC   | dot product open, accumulating until a last-tagged term
module mpc_dot_accum_29s_21s #(
    parameter int MUL_LAT    = 3,
    parameter int P_W        = 29,
    parameter int ACC_W      = 40,
    parameter int OUT_W      = 21,
    parameter int FRAC_SHIFT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             op_valid,
    input  logic             op_first,
    input  logic             op_last,
    input  logic [P_W-1:0]   p,
    output logic [OUT_W-1:0] y,
    output logic             y_valid,
    output logic             y_sat,
    output logic             busy,
    output logic             seq_err
);

    localparam logic signed [ACC_W:0] RND  = (ACC_W+1)'(64'sd1 <<< (FRAC_SHIFT-1));
    localparam logic signed [ACC_W:0] YMAX = (ACC_W+1)'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
    localparam logic signed [ACC_W:0] YMIN = (ACC_W+1)'(-(64'sd1 <<< (OUT_W-1)));

    typedef enum logic {IDLE, ACC} state_t;
    state_t state;

    logic [MUL_LAT-1:0]      v_sr, f_sr, l_sr;
    logic                    d_valid, d_first, d_last;
    logic signed [ACC_W-1:0] acc, p_ext, acc_base, acc_next;
    logic signed [ACC_W:0]   s_rnd, r;
    logic                    take, emit, clip_hi, clip_lo;

    assign d_valid = v_sr[MUL_LAT-1];
    assign d_first = f_sr[MUL_LAT-1];
    assign d_last  = l_sr[MUL_LAT-1];
    assign busy    = (state == ACC);

    // Tag delay line mirrors the multiplier pipeline, so it advances only with ce.
    if (MUL_LAT > 1) begin : g_tag_multi
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_sr <= '0;
                f_sr <= '0;
                l_sr <= '0;
            end else if (ce) begin
                v_sr <= {v_sr[MUL_LAT-2:0], op_valid};
                f_sr <= {f_sr[MUL_LAT-2:0], op_first};
                l_sr <= {l_sr[MUL_LAT-2:0], op_last};
            end
        end
    end else begin : g_tag_single
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_sr <= '0;
                f_sr <= '0;
                l_sr <= '0;
            end else if (ce) begin
                v_sr <= op_valid;
                f_sr <= op_first;
                l_sr <= op_last;
            end
        end
    end

    always_comb begin
        p_ext    = {{(ACC_W-P_W){p[P_W-1]}}, p};
        take     = ce & d_valid & (d_first | (state == ACC));
        emit     = take & d_last;
        acc_base = d_first ? '0 : acc;
        acc_next = acc_base + p_ext;
        // One guard bit so the rounding increment cannot wrap the sum.
        s_rnd    = $signed({acc_next[ACC_W-1], acc_next}) + RND;
        r        = s_rnd >>> FRAC_SHIFT;
        clip_hi  = (r > YMAX);
        clip_lo  = (r < YMIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            y       <= '0;
            y_valid <= 1'b0;
            y_sat   <= 1'b0;
            seq_err <= 1'b0;
        end else begin
            y_valid <= emit;
            y_sat   <= emit & (clip_hi | clip_lo);
            if (emit) begin
                if (clip_hi)
                    y <= YMAX[OUT_W-1:0];
                else if (clip_lo)
                    y <= YMIN[OUT_W-1:0];
                else
                    y <= r[OUT_W-1:0];
            end
            if (take)
                acc <= acc_next;
            if (ce && d_valid) begin
                case (state)
                    IDLE: begin
                        if (!d_first)
                            seq_err <= 1'b1;
                        else if (!d_last)
                            state <= ACC;
                    end
                    ACC: begin
                        if (d_first)
                            seq_err <= 1'b1;
                        if (d_last)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mpc_dot_accum_29s_21s.sv
// Scoreboard bench for mpc_dot_accum_29s_21s with a behavioural 3-stage product pipeline.
module tb_mpc_dot_accum_29s_21s;
    localparam int MUL_LAT = 3;

    logic               clk = 1'b0;
    logic               rst, ce, op_valid, op_first, op_last;
    logic signed [28:0] p, op_p;
    logic signed [28:0] pp [MUL_LAT];
    logic [20:0]        y;
    logic               y_valid, y_sat, busy, seq_err;

    typedef struct {
        int yv;
        bit sat;
        int at;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   last_t = 0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   busy_seen;

    mpc_dot_accum_29s_21s dut (
        .clk(clk), .rst(rst), .ce(ce), .op_valid(op_valid), .op_first(op_first),
        .op_last(op_last), .p(p), .y(y), .y_valid(y_valid), .y_sat(y_sat),
        .busy(busy), .seq_err(seq_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier stand-in: product appears MUL_LAT ce-qualified edges after its operands.
    always @(posedge clk) begin
        if (ce) begin
            pp[0] <= op_p;
            for (int i = 1; i < MUL_LAT; i++) pp[i] <= pp[i-1];
        end
    end
    assign p = pp[MUL_LAT-1];

    task automatic chk(input string name, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic term(input bit f, input bit l, input int pv);
        ce = 1'b1; op_valid = 1'b1; op_first = f; op_last = l; op_p = 29'(pv);
        last_t = cyc;
        @(posedge clk); #1;
        op_valid = 1'b0; op_first = 1'b0; op_last = 1'b0; op_p = '0;
    endtask

    task automatic gap(input int n, input bit c);
        ce = c;
        repeat (n) begin @(posedge clk); #1; end
        ce = 1'b1;
    endtask

    task automatic expect_y(input int yv, input bit s, input int at);
        exp_t x;
        x.yv = yv; x.sat = s; x.at = at;
        sb.push_back(x);
    endtask

    // Monitor: every y_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && y_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_y_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("y", int'($signed(y)), e.yv);
                chk("y_sat", int'(y_sat), int'(e.sat));
                if (e.at >= 0) chk("y_latency", cyc, e.at);
            end
        end
    end

    initial begin
        rst = 1'b1; ce = 1'b0; op_valid = 1'b0; op_first = 1'b0; op_last = 1'b0; op_p = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_y", int'(y), 0);
        chk("rst_y_valid", int'(y_valid), 0);
        chk("rst_y_sat", int'(y_sat), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_seq_err", int'(seq_err), 0);
        rst = 1'b0;
        gap(2, 1'b1);

        // T1: 640/256 = 2.5 rounds up to 3
        term(1, 0, 256); term(0, 0, 512); term(0, 1, -128);
        expect_y(3, 0, last_t + MUL_LAT + 1);
        gap(8, 1'b1);
        chk("t1_busy_after", int'(busy), 0);

        // T2: -1.5 rounds to -1, busy never rises
        term(1, 1, -384);
        expect_y(-1, 0, last_t + MUL_LAT + 1);
        busy_seen = 1'b0;
        repeat (8) begin @(negedge clk); busy_seen = busy_seen | busy; end
        chk("t2_busy_never", int'(busy_seen), 0);
        @(posedge clk); #1;

        // T3: saturation both ways and the exact upper boundary
        term(1, 0, 268435455); term(0, 1, 268435455);
        expect_y(1048575, 1, -1);
        term(1, 0, -268435456); term(0, 1, -268435456);
        expect_y(-1048576, 1, -1);
        term(1, 1, 268435200);
        expect_y(1048575, 0, -1);
        term(1, 0, 268435200); term(0, 1, 128);
        expect_y(1048575, 1, -1);
        gap(8, 1'b1);

        // T4: ce gaps freeze the pipeline; y_valid must still drop after one clock with ce low
        term(1, 0, 256); gap(2, 1'b0);
        term(0, 0, 512); gap(2, 1'b0);
        term(0, 1, -128);
        expect_y(3, 0, last_t + MUL_LAT + 1 + 2);
        gap(2, 1'b0);
        gap(3, 1'b1);
        gap(3, 1'b0);
        gap(4, 1'b1);

        // T5: orphan term while IDLE is dropped and flags seq_err
        term(0, 0, 1000);
        gap(6, 1'b1);
        chk("t5_seq_err_set", int'(seq_err), 1);
        term(1, 1, 1280);
        expect_y(5, 0, last_t + MUL_LAT + 1);
        gap(8, 1'b1);
        chk("t5_seq_err_sticky", int'(seq_err), 1);

        // T6: reset while a dot product is open discards it
        term(1, 0, 256); term(0, 0, 256); term(0, 1, 256);
        for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
        chk("t6_busy_open", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_y", int'(y), 0);
        chk("t6_rst_y_valid", int'(y_valid), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_seq_err", int'(seq_err), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        gap(8, 1'b1);
        term(1, 0, 256); term(0, 0, 512); term(0, 1, -128);
        expect_y(3, 0, last_t + MUL_LAT + 1);
        gap(8, 1'b1);

        // T7: first tag inside an open dot product restarts it: 512/256 + 0.5 -> 2
        term(1, 0, 256); term(1, 1, 512);
        expect_y(2, 0, last_t + MUL_LAT + 1);
        gap(8, 1'b1);
        chk("t7_seq_err", int'(seq_err), 1);
        chk("t7_busy", int'(busy), 0);

        for (int i = 0; i < 30 && sb.size() != 0; i++) @(posedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
